// File: rtl/mc_controller_pkg.sv
// Shared MIPS declarations: instruction field types, FSM states, ALU op classes
// and ALU control encodings used by the multicycle controller and its decoder.
package mips_decls_p;

    typedef logic [5:0] opcode_t;
    typedef logic [5:0] funct_t;

    localparam opcode_t OP_RTYPE = 6'b000000;
    localparam opcode_t OP_J     = 6'b000010;
    localparam opcode_t OP_BEQ   = 6'b000100;
    localparam opcode_t OP_ADDI  = 6'b001000;
    localparam opcode_t OP_LW    = 6'b100011;
    localparam opcode_t OP_SW    = 6'b101011;

    localparam funct_t FN_ADD = 6'b100000;
    localparam funct_t FN_SUB = 6'b100010;
    localparam funct_t FN_AND = 6'b100100;
    localparam funct_t FN_OR  = 6'b100101;
    localparam funct_t FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } statetype_t;

    typedef enum logic [1:0] {
        ADD   = 2'b00,
        SUB   = 2'b01,
        FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic opcode_supported(input opcode_t op);
        logic ok;
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: ok = 1'b1;
            default:                                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle: instruction fields and zero flag in,
// every select/enable plus debug state out.
interface mc_controller_if;
    import mips_decls_p::*;

    opcode_t    opcode;
    funct_t     funct;
    logic       zero;
    logic       pcen;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       alusrca;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal_op;
    statetype_t state;

    modport master (
        input  opcode, funct, zero,
        output pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg,
               regdst, alusrcb, pcsrc, alucontrol, illegal_op, state
    );

    modport slave (
        output opcode, funct, zero,
        input  pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg,
               regdst, alusrcb, pcsrc, alucontrol, illegal_op, state
    );
endinterface

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps the op class (and funct for R-type) to the 3-bit ALU control,
// flagging funct codes the ALU does not implement.
module aludec
    import mips_decls_p::*;
(
    input  aluop_t     aluop,
    input  funct_t     funct,
    output logic [2:0] alucontrol,
    output logic       illegal_funct
);

    // Op class / funct to ALU control decode
    always_comb begin
        alucontrol    = ALU_ADD;
        illegal_funct = 1'b0;
        case (aluop)
            ADD: alucontrol = ALU_ADD;
            SUB: alucontrol = ALU_SUB;
            FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: illegal_funct = 1'b1;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore main FSM driving all datapath selects and
// enables, with strobes held low while reset is asserted.
module mc_controller
    import mips_decls_p::*;
(
    input  logic           clk,
    input  logic           reset,
    mc_controller_if.master bus
);

    statetype_t state_r;
    statetype_t state_next_s;
    aluop_t     aluop_s;
    logic       pcwrite_s, branch_s, irwrite_s, regwrite_s, memwrite_s;
    logic       alusrca_s, iord_s, memtoreg_s, regdst_s, illegal_s;
    logic       illegal_funct_s;
    logic [1:0] alusrcb_s, pcsrc_s;
    logic [2:0] alucontrol_s;

    aludec U_ALUDEC (
        .aluop         (aluop_s),
        .funct         (bus.funct),
        .alucontrol    (alucontrol_s),
        .illegal_funct (illegal_funct_s)
    );

    // State register, cleared to FETCH asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = FETCH;
        case (state_r)
            FETCH: state_next_s = DECODE;
            DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_next_s = MEMADR;
                    OP_RTYPE:     state_next_s = RTYPEEX;
                    OP_BEQ:       state_next_s = BEQEX;
                    OP_ADDI:      state_next_s = ADDIEX;
                    OP_J:         state_next_s = JEX;
                    default:      state_next_s = FETCH;
                endcase
            end
            MEMADR: begin
                if (bus.opcode == OP_LW) begin
                    state_next_s = MEMRD;
                end else begin
                    state_next_s = MEMWR;
                end
            end
            MEMRD:   state_next_s = MEMWB;
            RTYPEEX: state_next_s = RTYPEWB;
            ADDIEX:  state_next_s = ADDIWB;
            default: state_next_s = FETCH;
        endcase
    end

    // Moore output decode; unreachable encodings leave every strobe low
    always_comb begin
        pcwrite_s  = 1'b0;
        branch_s   = 1'b0;
        irwrite_s  = 1'b0;
        regwrite_s = 1'b0;
        memwrite_s = 1'b0;
        alusrca_s  = 1'b0;
        iord_s     = 1'b0;
        memtoreg_s = 1'b0;
        regdst_s   = 1'b0;
        illegal_s  = 1'b0;
        alusrcb_s  = 2'b00;
        pcsrc_s    = 2'b00;
        aluop_s    = ADD;
        case (state_r)
            FETCH: begin
                irwrite_s = 1'b1;
                pcwrite_s = 1'b1;
                alusrcb_s = 2'b01;
            end
            DECODE: begin
                alusrcb_s = 2'b11;
                illegal_s = ~opcode_supported(bus.opcode);
            end
            MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
            end
            MEMRD: iord_s = 1'b1;
            MEMWB: begin
                memtoreg_s = 1'b1;
                regwrite_s = 1'b1;
            end
            MEMWR: begin
                iord_s     = 1'b1;
                memwrite_s = 1'b1;
            end
            RTYPEEX: begin
                alusrca_s = 1'b1;
                aluop_s   = FUNCT;
                illegal_s = illegal_funct_s;
            end
            RTYPEWB: begin
                regdst_s   = 1'b1;
                regwrite_s = 1'b1;
            end
            BEQEX: begin
                alusrca_s = 1'b1;
                aluop_s   = SUB;
                pcsrc_s   = 2'b01;
                branch_s  = 1'b1;
            end
            ADDIEX: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
            end
            ADDIWB: regwrite_s = 1'b1;
            JEX: begin
                pcsrc_s   = 2'b10;
                pcwrite_s = 1'b1;
            end
            default: aluop_s = ADD;
        endcase
    end

    // Write strobes and illegal flag are gated by reset so they drop at once
    assign bus.pcen       = reset & (pcwrite_s | (branch_s & bus.zero));
    assign bus.irwrite    = reset & irwrite_s;
    assign bus.regwrite   = reset & regwrite_s;
    assign bus.memwrite   = reset & memwrite_s;
    assign bus.illegal_op = reset & illegal_s;
    assign bus.alusrca    = alusrca_s;
    assign bus.iord       = iord_s;
    assign bus.memtoreg   = memtoreg_s;
    assign bus.regdst     = regdst_s;
    assign bus.alusrcb    = alusrcb_s;
    assign bus.pcsrc      = pcsrc_s;
    assign bus.alucontrol = alucontrol_s;
    assign bus.state      = state_r;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: each issued instruction pushes its expected
// per-cycle control vectors; a negedge monitor pops and compares every cycle.
module tb_mc_controller;
    import mips_decls_p::*;

    typedef struct packed {
        logic [3:0] st;
        logic       pcen, irwrite, regwrite, memwrite;
        logic       alusrca, iord, memtoreg, regdst;
        logic [1:0] alusrcb, pcsrc;
        logic [2:0] aluc;
        logic       illegal;
    } obs_t;

    logic clk;
    logic reset;
    mc_controller_if bus ();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t expq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    function automatic obs_t quiet(input statetype_t s);
        obs_t o;
        o      = '0;
        o.st   = s;
        o.aluc = 3'b010;
        return o;
    endfunction

    function automatic obs_t reset_view();
        obs_t o;
        o         = quiet(FETCH);
        o.alusrcb = 2'b01;
        return o;
    endfunction

    // Reference: ALU result code for an R-type funct; ok=0 for unknown ones
    function automatic logic [2:0] rtype_alu(input logic [5:0] fn, output logic ok);
        ok = 1'b1;
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default: begin
                ok = 1'b0;
                return 3'b010;
            end
        endcase
    endfunction

    // Reference: the full cycle-by-cycle control sequence of one instruction
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         output obs_t seq[$]);
        obs_t o;
        logic ok;
        seq.delete();
        o = quiet(FETCH); o.pcen = 1'b1; o.irwrite = 1'b1; o.alusrcb = 2'b01;
        seq.push_back(o);
        o = quiet(DECODE); o.alusrcb = 2'b11;
        o.illegal = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010});
        seq.push_back(o);
        if (op == 6'b100011 || op == 6'b101011) begin
            o = quiet(MEMADR); o.alusrca = 1'b1; o.alusrcb = 2'b10;
            seq.push_back(o);
            if (op == 6'b100011) begin
                o = quiet(MEMRD); o.iord = 1'b1;
                seq.push_back(o);
                o = quiet(MEMWB); o.memtoreg = 1'b1; o.regwrite = 1'b1;
                seq.push_back(o);
            end else begin
                o = quiet(MEMWR); o.iord = 1'b1; o.memwrite = 1'b1;
                seq.push_back(o);
            end
        end else if (op == 6'b000000) begin
            o = quiet(RTYPEEX); o.alusrca = 1'b1;
            o.aluc = rtype_alu(fn, ok); o.illegal = !ok;
            seq.push_back(o);
            o = quiet(RTYPEWB); o.regdst = 1'b1; o.regwrite = 1'b1;
            seq.push_back(o);
        end else if (op == 6'b000100) begin
            o = quiet(BEQEX); o.alusrca = 1'b1; o.aluc = 3'b110; o.pcsrc = 2'b01; o.pcen = z;
            seq.push_back(o);
        end else if (op == 6'b001000) begin
            o = quiet(ADDIEX); o.alusrca = 1'b1; o.alusrcb = 2'b10;
            seq.push_back(o);
            o = quiet(ADDIWB); o.regwrite = 1'b1;
            seq.push_back(o);
        end else if (op == 6'b000010) begin
            o = quiet(JEX); o.pcsrc = 2'b10; o.pcen = 1'b1;
            seq.push_back(o);
        end
    endtask

    // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 back in FETCH
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        obs_t seq[$];
        build(op, fn, z, seq);
        bus.opcode = op;
        bus.funct  = fn;
        bus.zero   = z;
        foreach (seq[i]) expq.push_back(seq[i]);
        repeat (seq.size()) @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle with an outstanding expectation is compared mid-cycle
    always @(negedge clk) begin
        obs_t act, exp;
        cyc++;
        if (expq.size() > 0) begin
            exp = expq.pop_front();
            act = {bus.state, bus.pcen, bus.irwrite, bus.regwrite, bus.memwrite,
                   bus.alusrca, bus.iord, bus.memtoreg, bus.regdst,
                   bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.illegal_op};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL ctrl cycle %0d: got state=%0d vec=%h, want state=%0d vec=%h",
                         cyc, act.st, act, exp.st, exp);
            end
        end
    end

    initial begin
        obs_t seq[$];
        logic [5:0] op, fn;
        logic [5:0] ops [7];
        logic [5:0] fns [5];
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        reset      = 1'b0;
        bus.opcode = 6'b000000;
        bus.funct  = 6'b000000;
        bus.zero   = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            expq.push_back(reset_view());
        end
        @(posedge clk); #1;
        reset = 1'b1;

        run_instr(6'b100011, 6'b000000, 1'b0);   // LW
        run_instr(6'b000000, 6'b101010, 1'b0);   // R-type SLT
        run_instr(6'b000100, 6'b000000, 1'b1);   // BEQ taken
        run_instr(6'b000100, 6'b000000, 1'b0);   // BEQ not taken
        run_instr(6'b101011, 6'b000000, 1'b0);   // SW
        run_instr(6'b111111, 6'b000000, 1'b0);   // unsupported opcode
        run_instr(6'b000000, 6'b111111, 1'b0);   // unsupported funct
        run_instr(6'b001000, 6'b000000, 1'b0);   // ADDI
        run_instr(6'b000010, 6'b000000, 1'b1);   // J

        // LW interrupted by reset between edges while in MEMRD
        build(6'b100011, 6'b000000, 1'b0, seq);
        bus.opcode = 6'b100011;
        for (int i = 0; i < 3; i++) expq.push_back(seq[i]);
        repeat (3) @(posedge clk);
        #1;
        expq.push_back(reset_view());
        #1 reset = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            expq.push_back(reset_view());
        end
        @(posedge clk); #1;
        reset = 1'b1;
        run_instr(6'b001000, 6'b000000, 1'b0);

        for (int n = 0; n < 80; n++) begin
            op = ops[$urandom_range(0, 6)];
            if (op == 6'b111111) op = 6'($urandom);
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            run_instr(op, fn, 1'($urandom));
        end

        @(negedge clk); #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle MIPS control unit; sits directly upstream of the datapath and drives every datapath select and enable each cycle.
- Consumes opcode, funct and zero from the datapath.
- Provides memwrite to memory.
- Moore main FSM plus a combinational ALU decoder.

Parameters:
none

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low (asserted when 0)
opcode  input  opcode_t (6)  instr[31:26] from datapath
funct  input  funct_t (6)  instr[5:0] from datapath
zero  input  1  ALU zero flag (combinational, same cycle)
pcen  output  1  PC register enable
irwrite  output  1  instruction register enable
regwrite  output  1  register file write enable
memwrite  output  1  memory write strobe
alusrca  output  1  0=PC, 1=A register
iord  output  1  0=PC, 1=ALUOut as memory address
memtoreg  output  1  0=ALUOut, 1=MDR to register file
regdst  output  1  0=rt, 1=rd as destination
alusrcb  output  2  00=B, 01=4, 10=signimm, 11=signimm<<2
pcsrc  output  2  00=ALU result, 01=ALUOut, 10=jump target
alucontrol  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
illegal_op  output  1  unsupported opcode/funct detected
state  output  statetype_t (4)  current FSM state, for debug

Behaviour:
- State register
  - Async clear to FETCH on reset==0.
  - While reset==0, pcen, irwrite, regwrite, memwrite and illegal_op are forced 0.
  - All other outputs take their FETCH values: alusrcb=01, all others 0, alucontrol=010.
- Transitions
  - FETCH->DECODE.
  - DECODE->MEMADR (LW/SW), RTYPEEX (R-type), BEQEX (BEQ), ADDIEX (ADDI), JEX (J); any other opcode->FETCH.
  - MEMADR->MEMRD (LW) or MEMWR (SW).
  - MEMRD->MEMWB.
  - RTYPEEX->RTYPEWB.
  - ADDIEX->ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX->FETCH.
- Instruction latency in cycles: LW 5; SW, R-type, ADDI 4; BEQ, J 3; illegal 2.
- Per-state outputs (unlisted = 0, alusrcb 00, pcsrc 00):
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=ADD.
  - DECODE: alusrcb=11, aluop=ADD (branch target precompute).
  - MEMADR: alusrca=1, alusrcb=10, aluop=ADD.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - RTYPEEX: alusrca=1, aluop=FUNCT.
  - RTYPEWB: regdst=1, regwrite=1.
  - BEQEX: alusrca=1, aluop=SUB, pcsrc=01, branch=1.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=ADD.
  - ADDIWB: regwrite=1.
  - JEX: pcsrc=10, pcwrite=1.
- pcen = pcwrite | (branch & zero), combinational. zero is sampled in the same cycle as BEQEX.
- ALU decode:
  - aluop ADD->010; SUB->110.
  - FUNCT: ADD 010, SUB 110, AND 000, OR 001, SLT 111.
  - Any other funct: alucontrol=010 and illegal_op=1 during RTYPEEX, still completes RTYPEWB (no trap).
- illegal_op pulses high for exactly the DECODE cycle when the opcode is unsupported. No register/memory write occurs for that instruction.
- Reset mid-instruction (any state): immediate return to FETCH, all strobes 0. The first fetch begins on the first rising edge after reset deasserts.
- No X on any output in any reachable state. An unreachable state encoding decodes to FETCH next with all strobes 0.

Decomposition:
- mips_decls_p gains:
  - statetype_t enum (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX).
  - aluop_t enum (ADD, SUB, FUNCT).
  - alucontrol localparams (ALU_ADD=010, ALU_SUB=110, ALU_AND=000, ALU_OR=001, ALU_SLT=111).
- Reuse the existing opcode_t and funct_t.
- One sub-module: aludec (aluop, funct -> alucontrol, illegal funct flag). Instance name U_ALUDEC.

Test Plan:
- Release reset, opcode=LW (100011) held -> state FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH.
  - regwrite=1 and memtoreg=1 only in MEMWB.
  - iord=1 only in MEMRD.
- opcode=R-type, funct=SLT (101010) -> alucontrol=111 and alusrca=1 in RTYPEEX; regdst=1, regwrite=1 in RTYPEWB.
- opcode=BEQ (000100):
  - with zero=1 -> pcen=1, pcsrc=01, alucontrol=110 in BEQEX.
  - repeat with zero=0 -> pcen=0.
  - Both cases return to FETCH after 3 cycles.
- opcode=SW (101011) -> memwrite=1, iord=1 only in MEMWR; regwrite never 1; 4-cycle sequence.
- opcode=111111 -> illegal_op=1 in DECODE; next state FETCH; no regwrite/memwrite.
- reset=0 asserted asynchronously mid-MEMRD (between edges) -> state=FETCH immediately, pcen=irwrite=regwrite=memwrite=0 until release.
  - First edge after release: state goes FETCH->DECODE with irwrite=1, pcen=1 in the cycle before.
